filter_dot_engine: RTL
======================

Name: filter_dot_engine

Overview:
- Downstream consumer of the per-filter weight RAM, which holds 5 weights plus 1 bias per filter.
- On Start, latches a 5-element input vector, then walks the filter index 0..Nr_depth-1 driving the RAM read port.
- For each filter it computes sum(w_i*x_i) + bias, requantises by arithmetic right shift, applies optional ReLU, saturates, and emits one result per filter.
- Fully pipelined: one filter per clock after fill.

Parameters:
- Bit_width, 8: signed width of data, weights, bias and result.
- Nr_depth, 8: number of filters to evaluate per run.
- Depth_counter_bits, 3: filter index width; 2**Depth_counter_bits >= Nr_depth.
- Out_shift, 4: arithmetic right shift applied to the accumulator before saturation, range 0..Bit_width+3.

Ports:
- Clk  in  1  clock, posedge logic.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  begin a run; sampled only in IDLE.
- Relu_en  in  1  sampled at Start; when 1, negative results are forced to 0.
- Data_in_0..Data_in_4  in  Bit_width each  signed input vector; sampled at Start.
- Weight_read_en  out  1  read enable to the weight RAM.
- Weight_addr  out  Depth_counter_bits  filter index to the weight RAM.
- Weight_in_0..Weight_in_4  in  Bit_width each  signed weights from the RAM.
- Weight_in_5  in  Bit_width  signed bias from the RAM.
- Result_out  out  Bit_width  signed saturated result.
- Result_valid  out  1  Result_out valid this cycle.
- Result_index  out  Depth_counter_bits  filter index of Result_out.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse with the last result.

Behaviour:
- Reset: asynchronous, active-high. Every output and every internal register clears to 0 and the FSM enters IDLE.
- Reset mid-run: the run is aborted, no Done is issued, and no further Result_valid appears.
- FSM states:
  - IDLE: Start=1 latches Data_in_* and Relu_en, sets Busy=1, goes to ISSUE.
  - ISSUE: for Nr_depth cycles, Weight_read_en=1 and Weight_addr = k, registered, for k = 0..Nr_depth-1. After k = Nr_depth-1, go to DRAIN.
  - DRAIN: Weight_read_en=0; wait 3 cycles for the pipeline to empty, then return to IDLE with Busy=0.
  - Busy is cleared on the same edge that raises the final Result_valid/Done.
- Start while Busy is ignored.
- Start on the same cycle Done is high is ignored; Start is accepted the following cycle.
- RAM timing: the RAM updates its outputs on the negedge following an address/enable issued at posedge t. Weight_in_* are sampled at posedge t+1.
- Pipeline, with the address issued at posedge t:
  - P1 (posedge t+1): five signed products (2*Bit_width bits each) registered; bias registered.
  - P2 (posedge t+2): accumulator = sum of products + sign-extended bias, width 2*Bit_width+3, no overflow possible.
  - P3 (posedge t+3): acc >>> Out_shift (arithmetic, floor toward -inf). If latched Relu_en is set and the value is negative, force 0. Saturate to [-2**(Bit_width-1), 2**(Bit_width-1)-1]. Register Result_out and Result_index = k, and set Result_valid=1.
  - Latency from address issue to Result_valid is 3 cycles. A run of Nr_depth filters takes Nr_depth+3 cycles from Start to Done.
- Result_valid is high for exactly one cycle per filter, on consecutive cycles, with indices in ascending order.
- Done=1 together with the Result_valid for index Nr_depth-1 only.
- When Result_valid=0, Result_out and Result_index hold their last values.
- Weight_addr holds its last value outside ISSUE.
- Data_in_* may change freely after Start without affecting the run.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE/ISSUE/DRAIN.
  - Derived localparam ACC_WIDTH = 2*Bit_width+3.
  - Saturation bound constants.
- One natural sub-module, filter_dot_pipe: the 3-stage multiply/sum/requantise datapath with a valid/index sideband.
- The top level holds the FSM, counters and input latch.

Test Plan:
- Basic sum, Out_shift=0, filter k weights all = k, bias = k, data all 2, Relu_en=0 -> Result_valid on 8 consecutive cycles starting 3 cycles after the first issue, results 0,11,22,…,77 at indices 0..7, Done with index 7.
- Positive saturation, Out_shift=4, weights 127, data 127, bias 0 -> acc 80645 >>> 4 = 5040 -> Result_out = 127 for every filter.
- Negative floor and ReLU, Out_shift=4, weights -1, data 100, bias 0 -> -500 >>> 4 = -32. With Relu_en=0 the result is -32 (0xE0); rerun with Relu_en=1 and the result is 0.
- Negative saturation, Out_shift=0, weights -128, data 127, bias -128 -> Result_out = -128.
- Start ignored while Busy: pulse Start at the 3rd cycle of a run with changed Data_in -> exactly 8 results from the original data and one Done; Start one cycle after Done launches a new run.
- Reset mid-run: assert Rst during ISSUE at k=4 -> all outputs are 0 immediately (asynchronous); after release, no Result_valid or Done appears until the next Start.

Source files
------------

// File: rtl/filter_dot_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_dot_engine_pkg
//  Description : Shared definitions for the filter dot-product engine:
//                FSM state encodings, tap count, accumulator width and
//                saturation bound helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_dot_engine_pkg;

    // Number of data/weight taps per filter (the bias is a sixth RAM word)
    localparam int c_NUM_TAPS = 5;

    // FSM state encodings
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;

    // Cycles spent in DRAIN while the three pipeline stages empty
    localparam int c_DRAIN_CYCLES = 3;

    // Default configuration and its derived accumulator width
    localparam int c_DEF_BIT_WIDTH = 8;
    localparam int c_ACC_WIDTH     = 2 * c_DEF_BIT_WIDTH + 3;

    // Five 2*bw products plus a bw bias need 3 guard bits to never overflow
    function automatic int acc_width(input int bw);
        return 2 * bw + 3;
    endfunction

    // Saturation bounds of a signed bw-bit result
    function automatic int sat_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int bw);
        return -(1 << (bw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_dot_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : filter_dot_engine_if
//  Description : Bus bundle of the filter dot-product engine.
//                Control   : start, relu_en, busy, done
//                Vector    : data_in_0..4
//                RAM port  : weight_read_en, weight_addr, weight_in_0..5
//                Results   : result_out, result_valid, result_index
//                modport slave  - the engine
//                modport master - the controller / weight RAM side
//  Revision    : 1.0 - initial release
// ============================================================================
interface filter_dot_engine_if #(
    parameter int BIT_WIDTH          = 8,
    parameter int DEPTH_COUNTER_BITS = 3
);
    logic                          start;
    logic                          relu_en;
    logic signed [BIT_WIDTH-1:0]   data_in_0;
    logic signed [BIT_WIDTH-1:0]   data_in_1;
    logic signed [BIT_WIDTH-1:0]   data_in_2;
    logic signed [BIT_WIDTH-1:0]   data_in_3;
    logic signed [BIT_WIDTH-1:0]   data_in_4;
    logic                          weight_read_en;
    logic [DEPTH_COUNTER_BITS-1:0] weight_addr;
    logic signed [BIT_WIDTH-1:0]   weight_in_0;
    logic signed [BIT_WIDTH-1:0]   weight_in_1;
    logic signed [BIT_WIDTH-1:0]   weight_in_2;
    logic signed [BIT_WIDTH-1:0]   weight_in_3;
    logic signed [BIT_WIDTH-1:0]   weight_in_4;
    logic signed [BIT_WIDTH-1:0]   weight_in_5;
    logic signed [BIT_WIDTH-1:0]   result_out;
    logic                          result_valid;
    logic [DEPTH_COUNTER_BITS-1:0] result_index;
    logic                          busy;
    logic                          done;

    modport slave (
        input  start, relu_en,
        input  data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        input  weight_in_0, weight_in_1, weight_in_2, weight_in_3, weight_in_4, weight_in_5,
        output weight_read_en, weight_addr,
        output result_out, result_valid, result_index, busy, done
    );

    modport master (
        output start, relu_en,
        output data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        output weight_in_0, weight_in_1, weight_in_2, weight_in_3, weight_in_4, weight_in_5,
        input  weight_read_en, weight_addr,
        input  result_out, result_valid, result_index, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/filter_dot_engine_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : filter_dot_pipe
//  Description : Three-stage multiply / sum / requantise datapath with a
//                valid + index sideband.
//                P1 registers five signed products and the bias, P2 the
//                accumulator, P3 the shifted, ReLU'd, saturated result.
//  Ports       : clk, rst             clock, async active-high reset
//                i_valid, i_index     RAM word valid this cycle + its filter
//                i_data, i_relu       latched input vector and ReLU enable
//                i_weight, i_bias     RAM outputs
//                o_result, o_valid, o_index, o_done   result stage
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_dot_pipe
    import filter_dot_engine_pkg::*;
#(
    parameter int BIT_WIDTH          = 8,
    parameter int NR_DEPTH           = 8,
    parameter int DEPTH_COUNTER_BITS = 3,
    parameter int OUT_SHIFT          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [DEPTH_COUNTER_BITS-1:0] i_index,
    input  logic                          i_relu,
    input  logic signed [BIT_WIDTH-1:0]   i_data   [c_NUM_TAPS],
    input  logic signed [BIT_WIDTH-1:0]   i_weight [c_NUM_TAPS],
    input  logic signed [BIT_WIDTH-1:0]   i_bias,
    output logic signed [BIT_WIDTH-1:0]   o_result,
    output logic                          o_valid,
    output logic [DEPTH_COUNTER_BITS-1:0] o_index,
    output logic                          o_done
);
    localparam int PROD_WIDTH = 2 * BIT_WIDTH;
    localparam int ACC_WIDTH  = acc_width(BIT_WIDTH);
    localparam int c_SAT_MAX  = sat_max(BIT_WIDTH);
    localparam int c_SAT_MIN  = sat_min(BIT_WIDTH);
    localparam logic [DEPTH_COUNTER_BITS-1:0] c_LAST_IDX = DEPTH_COUNTER_BITS'(NR_DEPTH - 1);

    logic signed [PROD_WIDTH-1:0]         w_prod [c_NUM_TAPS];
    logic signed [PROD_WIDTH-1:0]         r_prod [c_NUM_TAPS];
    logic signed [BIT_WIDTH-1:0]          r_bias;
    logic                                 r_valid1;
    logic [DEPTH_COUNTER_BITS-1:0]        r_idx1;
    logic signed [ACC_WIDTH-1:0]          w_acc;
    logic signed [ACC_WIDTH-1:0]          r_acc;
    logic                                 r_valid2;
    logic [DEPTH_COUNTER_BITS-1:0]        r_idx2;
    logic signed [ACC_WIDTH-1:0]          w_shifted;
    int                                   w_clip;
    logic signed [BIT_WIDTH-1:0]          w_result;

    // Operands are widened to the product width first so the multiply is
    // evaluated at full precision.
    for (genvar g = 0; g < c_NUM_TAPS; g++) begin : g_mul
        logic signed [PROD_WIDTH-1:0] w_a;
        logic signed [PROD_WIDTH-1:0] w_b;
        assign w_a       = {{BIT_WIDTH{i_data[g][BIT_WIDTH-1]}}, i_data[g]};
        assign w_b       = {{BIT_WIDTH{i_weight[g][BIT_WIDTH-1]}}, i_weight[g]};
        assign w_prod[g] = w_a * w_b;
    end

    always_comb begin
        w_acc = {{(ACC_WIDTH - BIT_WIDTH){r_bias[BIT_WIDTH-1]}}, r_bias};
        for (int i = 0; i < c_NUM_TAPS; i++) begin
            w_acc = w_acc + {{(ACC_WIDTH - PROD_WIDTH){r_prod[i][PROD_WIDTH-1]}}, r_prod[i]};
        end
    end

    // Arithmetic shift floors toward -inf; ReLU is applied before the clip
    always_comb begin
        w_shifted = r_acc >>> OUT_SHIFT;
        w_clip    = int'(w_shifted);
        if (i_relu && (w_clip < 0)) begin
            w_clip = 0;
        end
        if (w_clip > c_SAT_MAX) begin
            w_clip = c_SAT_MAX;
        end else if (w_clip < c_SAT_MIN) begin
            w_clip = c_SAT_MIN;
        end
        w_result = BIT_WIDTH'(w_clip);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_TAPS; i++) begin
                r_prod[i] <= '0;
            end
            r_bias   <= '0;
            r_valid1 <= 1'b0;
            r_idx1   <= '0;
            r_acc    <= '0;
            r_valid2 <= 1'b0;
            r_idx2   <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_index  <= '0;
            o_done   <= 1'b0;
        end else begin
            for (int i = 0; i < c_NUM_TAPS; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_bias   <= i_bias;
            r_valid1 <= i_valid;
            r_idx1   <= i_index;
            r_acc    <= w_acc;
            r_valid2 <= r_valid1;
            r_idx2   <= r_idx1;
            o_valid  <= r_valid2;
            o_done   <= r_valid2 && (r_idx2 == c_LAST_IDX);
            // Result and index hold their last values between valid cycles
            if (r_valid2) begin
                o_result <= w_result;
                o_index  <= r_idx2;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module      : filter_dot_engine
//  Description : Evaluates NR_DEPTH 5-tap filters (weights + bias read from
//                an external weight RAM) against a latched input vector, one
//                filter per clock, emitting requantised saturated results.
//  Ports       : clk    clock
//                rst    asynchronous active-high reset
//                bus    filter_dot_engine_if.slave (control, input vector,
//                       weight RAM read port, result stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_dot_engine
    import filter_dot_engine_pkg::*;
#(
    parameter int BIT_WIDTH          = 8,
    parameter int NR_DEPTH           = 8,
    parameter int DEPTH_COUNTER_BITS = 3,
    parameter int OUT_SHIFT          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    filter_dot_engine_if.slave    bus
);
    localparam logic [DEPTH_COUNTER_BITS-1:0] c_LAST_IDX   = DEPTH_COUNTER_BITS'(NR_DEPTH - 1);
    localparam logic [1:0]                    c_DRAIN_LAST = 2'(c_DRAIN_CYCLES - 1);

    logic [c_STATE_W-1:0]           r_state;
    logic [c_STATE_W-1:0]           w_state_next;
    logic                           w_accept;
    logic                           w_issue;
    logic                           w_drain;
    logic                           w_drain_last;

    logic signed [BIT_WIDTH-1:0]    r_data   [c_NUM_TAPS];
    logic signed [BIT_WIDTH-1:0]    w_weight [c_NUM_TAPS];
    logic                           r_relu;
    logic                           r_busy;
    logic                           r_read_en;
    logic [DEPTH_COUNTER_BITS-1:0]  r_addr;
    logic [DEPTH_COUNTER_BITS-1:0]  r_issue_cnt;
    logic [1:0]                     r_drain_cnt;

    logic signed [BIT_WIDTH-1:0]    w_result;
    logic                           w_valid;
    logic [DEPTH_COUNTER_BITS-1:0]  w_index;
    logic                           w_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_drain      = 1'b0;
        w_drain_last = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A Start coinciding with the Done pulse is not taken
                if (bus.start && !w_done) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_issue = 1'b1;
                if (r_issue_cnt == c_LAST_IDX) begin
                    w_state_next = c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_drain = 1'b1;
                // Third drain edge is the one that raises the last result
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_drain_last = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input latch, counters and RAM read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_TAPS; i++) begin
                r_data[i] <= '0;
            end
            r_relu      <= 1'b0;
            r_busy      <= 1'b0;
            r_read_en   <= 1'b0;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_read_en <= w_issue;
            if (w_accept) begin
                r_data[0]   <= bus.data_in_0;
                r_data[1]   <= bus.data_in_1;
                r_data[2]   <= bus.data_in_2;
                r_data[3]   <= bus.data_in_3;
                r_data[4]   <= bus.data_in_4;
                r_relu      <= bus.relu_en;
                r_busy      <= 1'b1;
                r_issue_cnt <= '0;
                r_drain_cnt <= '0;
            end
            if (w_issue) begin
                r_addr      <= r_issue_cnt;
                r_issue_cnt <= r_issue_cnt + DEPTH_COUNTER_BITS'(1);
            end
            if (w_drain) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
                if (w_drain_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_weight[0] = bus.weight_in_0;
        w_weight[1] = bus.weight_in_1;
        w_weight[2] = bus.weight_in_2;
        w_weight[3] = bus.weight_in_3;
        w_weight[4] = bus.weight_in_4;
    end

    // ------------------------------------------------------------------
    // Datapath: RAM words arrive one cycle after the address, so the
    // registered enable/address double as the pipeline's valid/index.
    // ------------------------------------------------------------------
    filter_dot_pipe #(
        .BIT_WIDTH          (BIT_WIDTH),
        .NR_DEPTH           (NR_DEPTH),
        .DEPTH_COUNTER_BITS (DEPTH_COUNTER_BITS),
        .OUT_SHIFT          (OUT_SHIFT)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_read_en),
        .i_index  (r_addr),
        .i_relu   (r_relu),
        .i_data   (r_data),
        .i_weight (w_weight),
        .i_bias   (bus.weight_in_5),
        .o_result (w_result),
        .o_valid  (w_valid),
        .o_index  (w_index),
        .o_done   (w_done)
    );

    assign bus.weight_read_en = r_read_en;
    assign bus.weight_addr    = r_addr;
    assign bus.result_out     = w_result;
    assign bus.result_valid   = w_valid;
    assign bus.result_index   = w_index;
    assign bus.busy           = r_busy;
    assign bus.done           = w_done;

endmodule
`default_nettype wire
